adder_share_arbiter: RTL and testbench
======================================

// Module: adder_share_arbiter
// PURPOSE
// - Shares one combinational 32-bit adder/subtractor (RCA/CLA/CSKA class) between NUM_REQ requesters.
// - Requesters are, for example, the UART operand path and an on-chip self-test generator.
// - Round-robin arbitration; grants one operation at a time.
// - Operands are registered into the adder and held for SETTLE_CYC cycles (multicycle path for slow adders).
// - The result is captured and returned over a per-requester valid/ready response channel.
// PARAMETERS
// - NUM_REQ     2   number of requesters, 2..8
// - WIDTH       32  operand/result width
// - SETTLE_CYC  2   cycles operands are held on the adder before capture, >=1
// PORTS
// - sys_clk     in   1              system clock, all logic on rising edge
// - rst         in   1              asynchronous reset, active-low
// - req_valid   in   NUM_REQ        per-requester operation request
// - req_ready   out  NUM_REQ        one-hot pulse, request accepted this cycle
// - req_sub     in   NUM_REQ        1 = subtract
// - req_operA   in   NUM_REQ*WIDTH  flattened; requester i at [i*WIDTH +: WIDTH]
// - req_operB   in   NUM_REQ*WIDTH  flattened, same packing as req_operA
// - rsp_valid   out  NUM_REQ        one-hot, result pending for requester i
// - rsp_ready   in   NUM_REQ        requester i takes result
// - rsp_sum     out  WIDTH          shared result bus, valid while any rsp_valid
// - rsp_cout    out  1              carry out of the captured result
// - add_cin     out  1              to adder Cin
// - add_operA   out  WIDTH          to adder operA (already inverted for sub)
// - add_operB   out  WIDTH          to adder operB
// - add_result  in   WIDTH          from adder resultOUT
// - add_cout    in   1              from adder Cout
// - busy        out  1              FSM not in IDLE
// BEHAVIOUR
// - Reset (rst=0, asynchronous):
//   - all outputs 0; FSM to IDLE; rr pointer to 0 (requester 0 highest priority); in-flight op dropped.
// - FSM states: IDLE, SETTLE, RESP.
// - IDLE:
//   - if any req_valid, grant the first set bit searching from (last_grant+1) mod NUM_REQ; after reset the search starts at 0.
//   - req_ready[g]=1 combinationally in that cycle only.
//   - register add_operA = sub ? ~A : A, add_operB = B, add_cin = sub; load counter = SETTLE_CYC-1; -> SETTLE.
// - SETTLE:
//   - operands held stable.
//   - counter==0: capture rsp_sum<=add_result, rsp_cout<=add_cout, rsp_valid[g]<=1; -> RESP. Else decrement.
// - RESP:
//   - rsp_valid[g], rsp_sum and rsp_cout held stable until rsp_ready[g]=1.
//   - on that cycle, rsp_valid clears and last_grant<=g; -> IDLE. rsp_ready of other requesters is ignored.
// - Latency: accept at cycle 0; rsp_valid rises at cycle SETTLE_CYC+1; minimum issue interval SETTLE_CYC+2.
// - Arithmetic (mod 2^WIDTH):
//   - add: A+B, cout = carry.
//   - sub: B-A via ~A+B+1; cout=1 means no borrow (B>=A unsigned).
// - Requests in non-IDLE states are not accepted (req_ready=0); a requester may drop req_valid before its grant without effect.
// - Simultaneous requests: exactly one granted per IDLE cycle; losers keep req_valid asserted and win within NUM_REQ grants (no starvation).
// - add_operA/add_operB/add_cin keep their last values in IDLE and RESP (no toggling).
// CONFIGURATION
// - OVF_FLAG_EN defined:
//   - adds output rsp_ovf (1 bit), captured with rsp_sum.
//   - rsp_ovf = signed two's-complement overflow of the performed op, i.e. (add_operA[MSB]==add_operB[MSB]) && (add_result[MSB]!=add_operA[MSB]).
//   - rsp_ovf is 0 on reset.
// - OVF_FLAG_EN undefined: port rsp_ovf absent; no extra logic.
// TESTING
// - Reset: rst=0 mid-SETTLE -> all outputs 0 immediately; after release, a req0 add 5+7 returns rsp_sum=12, cout=0 at cycle 3 (SETTLE_CYC=2).
// - Add wrap: A=32'hFFFF_FFFF, B=1, sub=0 -> rsp_sum=0, rsp_cout=1.
// - Subtract: A=3, B=10, sub=1 -> rsp_sum=7, cout=1; A=10, B=3 -> rsp_sum=32'hFFFF_FFF9, cout=0.
// - Arbitration: req0 and req1 valid together from reset, rsp_ready tied 1 -> grants 0,1,0,1; each rsp_valid one-hot to the granted index.
// - Backpressure: rsp_ready=0 for 20 cycles -> rsp_valid, rsp_sum and busy held; req_ready stays 0; release -> next grant 1 cycle later.
// - OVF_FLAG_EN: A=32'h7FFF_FFFF, B=1, add -> rsp_ovf=1; A=1, B=1 -> rsp_ovf=0.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one external combinational adder/subtractor between NUM_REQ requesters.
// Optional macro OVF_FLAG_EN adds rsp_ovf, the signed overflow flag captured with each result.
module adder_share_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int WIDTH      = 32,
  parameter int SETTLE_CYC = 2
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_sub,
  input  logic [NUM_REQ*WIDTH-1:0] req_operA,
  input  logic [NUM_REQ*WIDTH-1:0] req_operB,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
`ifdef OVF_FLAG_EN
  output logic                     rsp_ovf,
`endif
  output logic                     add_cin,
  output logic [WIDTH-1:0]         add_operA,
  output logic [WIDTH-1:0]         add_operB,
  input  logic [WIDTH-1:0]         add_result,
  input  logic                     add_cout,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  // Handshakes: a request transfers in the cycle req_valid[i] && req_ready[i];
  // a response transfers in the cycle rsp_valid[i] && rsp_ready[i], and
  // rsp_valid/rsp_sum/rsp_cout stay stable until that cycle.

  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IW1 = IW + 1;
  localparam int CW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt;
  logic [CW-1:0]   cnt;
  logic            gnt_any;
  logic [IW-1:0]   gnt_idx;
  logic [IW:0]     cand;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // Descending scan so the candidate closest to ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + IW1'(k);
      if (cand >= IW1'(NUM_REQ)) cand = cand - IW1'(NUM_REQ);
      if (req_valid[cand[IW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
  end

  assign sel_a = req_operA[gnt_idx*WIDTH +: WIDTH];
  assign sel_b = req_operB[gnt_idx*WIDTH +: WIDTH];

  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = SETTLE;
      SETTLE:  if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready[gnt]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Adder operands only change on acceptance, so the multicycle path stays quiet otherwise.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      gnt       <= '0;
      cnt       <= '0;
      add_operA <= '0;
      add_operB <= '0;
      add_cin   <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_valid <= '0;
`ifdef OVF_FLAG_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            gnt       <= gnt_idx;
            add_operA <= req_sub[gnt_idx] ? ~sel_a : sel_a;
            add_operB <= sel_b;
            add_cin   <= req_sub[gnt_idx];
            cnt       <= CW'(SETTLE_CYC - 1);
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            rsp_sum   <= add_result;
            rsp_cout  <= add_cout;
            rsp_valid <= NUM_REQ'(1) << gnt;
`ifdef OVF_FLAG_EN
            rsp_ovf   <= (add_operA[WIDTH-1] == add_operB[WIDTH-1]) &&
                         (add_result[WIDTH-1] != add_operA[WIDTH-1]);
`endif
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready[gnt]) begin
            rsp_valid <= '0;
            ptr       <= (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed cases plus randomized traffic against a transaction-level model.
module tb_adder_share_arbiter;

  localparam int NUM_REQ    = 2;
  localparam int WIDTH      = 32;
  localparam int SETTLE_CYC = 2;

  logic                     sys_clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_sub;
  logic [NUM_REQ*WIDTH-1:0] req_operA;
  logic [NUM_REQ*WIDTH-1:0] req_operB;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;
`ifdef OVF_FLAG_EN
  logic                     rsp_ovf;
`endif
  logic                     add_cin;
  logic [WIDTH-1:0]         add_operA;
  logic [WIDTH-1:0]         add_operB;
  logic [WIDTH-1:0]         add_result;
  logic                     add_cout;
  logic                     busy;
  logic [1:0]               dbg_state;

  adder_share_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .sys_clk(sys_clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
    .req_operA(req_operA), .req_operB(req_operB),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
`ifdef OVF_FLAG_EN
    .rsp_ovf(rsp_ovf),
`endif
    .add_cin(add_cin), .add_operA(add_operA), .add_operB(add_operB),
    .add_result(add_result), .add_cout(add_cout),
    .busy(busy), .dbg_state(dbg_state)
  );

  // External combinational adder.
  assign {add_cout, add_result} = {1'b0, add_operA} + {1'b0, add_operB} + {{WIDTH{1'b0}}, add_cin};

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected {ovf, cout, sum} per accepted op, oldest first.
  logic [WIDTH+1:0] exp_q[$];

  function automatic logic [WIDTH+1:0] ref_op(input logic sub, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    logic           ovf;
    if (!sub) begin
      s   = {1'b0, a} + {1'b0, b};
      ovf = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    end else begin
      s[WIDTH-1:0] = b - a;
      s[WIDTH]     = (b >= a);
      ovf          = (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != b[WIDTH-1]);
    end
    return {ovf, s};
  endfunction

  // Transaction model: idle, or one op in flight m_age cycles after its accept cycle.
  bit               m_active = 0;
  int               m_owner = 0;
  int               m_age = 0;
  int               m_start = 0;
  logic [WIDTH-1:0] m_opa = '0;
  logic [WIDTH-1:0] m_opb = '0;
  logic             m_cin = 1'b0;
  int               win;
  logic [NUM_REQ-1:0] e_ready;
  logic [NUM_REQ-1:0] e_rvalid;
  logic [WIDTH-1:0] ma;
  logic [WIDTH-1:0] mb;
  logic             ms;

  always @(negedge sys_clk) begin
    if (!rst) begin
      chk("reset ctl", 64'({busy, req_ready, rsp_valid, rsp_cout, add_cin}), 64'(0));
      chk("reset data", 64'(rsp_sum | add_operA | add_operB), 64'(0));
`ifdef OVF_FLAG_EN
      chk("reset ovf", 64'(rsp_ovf), 64'(0));
`endif
      m_active = 0; m_start = 0; m_age = 0;
      m_opa = '0; m_opb = '0; m_cin = 1'b0;
      exp_q.delete();
    end else begin
      win = -1;
      if (!m_active)
        for (int k = 0; k < NUM_REQ; k++)
          if (win < 0 && req_valid[(m_start + k) % NUM_REQ]) win = (m_start + k) % NUM_REQ;
      e_ready = '0;
      if (win >= 0) e_ready[win] = 1'b1;
      e_rvalid = '0;
      if (m_active && m_age >= SETTLE_CYC + 1) e_rvalid[m_owner] = 1'b1;
      chk("busy", 64'(busy), 64'(m_active));
      chk("req_ready", 64'(req_ready), 64'(e_ready));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rvalid));
      chk("add_operA", 64'(add_operA), 64'(m_opa));
      chk("add_operB/cin", 64'({add_cin, add_operB}), 64'({m_cin, m_opb}));
      if (e_rvalid != '0 && exp_q.size() > 0) begin
        chk("rsp_sum/cout", 64'({rsp_cout, rsp_sum}), 64'(exp_q[0][WIDTH:0]));
`ifdef OVF_FLAG_EN
        chk("rsp_ovf", 64'(rsp_ovf), 64'(exp_q[0][WIDTH+1]));
`endif
      end
      if (!m_active) begin
        if (win >= 0) begin
          ma = req_operA[win*WIDTH +: WIDTH];
          mb = req_operB[win*WIDTH +: WIDTH];
          ms = req_sub[win];
          m_active = 1; m_age = 1; m_owner = win;
          m_opa = ms ? ~ma : ma; m_opb = mb; m_cin = ms;
          exp_q.push_back(ref_op(ms, ma, mb));
        end
      end else if (m_age >= SETTLE_CYC + 1) begin
        if (rsp_ready[m_owner]) begin
          m_active = 0;
          m_start  = (m_owner + 1) % NUM_REQ;
          void'(exp_q.pop_front());
        end
      end else begin
        m_age++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int r, input logic sub, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
    req_valid[r] = 1'b1;
    req_sub[r]   = sub;
    req_operA[r*WIDTH +: WIDTH] = a;
    req_operB[r*WIDTH +: WIDTH] = b;
  endtask

  task automatic wait_accept(input int r, input string name);
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge sys_clk);
      seen = req_ready[r];
    end
    chk({name, " accept"}, 64'(seen), 64'(1));
  endtask

  // One op with rsp_ready assumed high for r; checks latency and result literals.
  task automatic do_op(input int r, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic sub, input logic [WIDTH-1:0] e_sum, input logic e_cout,
                       input string name, output logic ovf);
    int cyc;
    bit seen;
    @(posedge sys_clk); #2;
    drive_req(r, sub, a, b);
    wait_accept(r, name);
    @(posedge sys_clk); #2;
    req_valid[r] = 1'b0;
    cyc = 1; seen = 0; ovf = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge sys_clk);
      if (rsp_valid[r]) seen = 1;
      else cyc++;
    end
    chk({name, " latency"}, 64'(cyc), 64'(SETTLE_CYC + 1));
    chk({name, " sum"}, 64'(rsp_sum), 64'(e_sum));
    chk({name, " cout"}, 64'(rsp_cout), 64'(e_cout));
`ifdef OVF_FLAG_EN
    ovf = rsp_ovf;
`endif
  endtask

  task automatic wait_idle(input string name);
    bit idle = 0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge sys_clk);
      idle = !busy;
    end
    chk({name, " idle"}, 64'(idle), 64'(1));
  endtask

  task automatic apply_reset();
    @(posedge sys_clk); #2;
    rst = 1'b0;
    @(posedge sys_clk); #2;
    rst = 1'b1;
  endtask

  function automatic logic [WIDTH-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic             ovf_v;
  logic [WIDTH-1:0] snap;
  logic [NUM_REQ-1:0] grant_exp[4];
  bit               got;

  initial begin
    rst = 1'b1; req_valid = '0; req_sub = '0; req_operA = '0; req_operB = '0; rsp_ready = '1;
    #1 rst = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2 rst = 1'b1;

    // Reset mid-SETTLE drops the op and clears outputs immediately.
    @(posedge sys_clk); #2;
    drive_req(0, 1'b0, 32'd1, 32'd2);
    wait_accept(0, "pre-reset op");
    @(posedge sys_clk); #2;
    req_valid = '0;
    #1 rst = 1'b0;
    #1 chk("async reset ctl", 64'({busy, req_ready, rsp_valid, rsp_cout, add_cin}), 64'(0));
    chk("async reset operands", 64'({add_operA, add_operB} != '0), 64'(0));
    @(posedge sys_clk); #2;
    rst = 1'b1;

    do_op(0, 32'd5, 32'd7, 1'b0, 32'd12, 1'b0, "add 5+7", ovf_v);
    do_op(0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, "add wrap", ovf_v);
    do_op(1, 32'd3, 32'd10, 1'b1, 32'd7, 1'b1, "sub 10-3", ovf_v);
    do_op(0, 32'd10, 32'd3, 1'b1, 32'hFFFF_FFF9, 1'b0, "sub 3-10", ovf_v);
`ifdef OVF_FLAG_EN
    do_op(0, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, "ovf add", ovf_v);
    chk("ovf set", 64'(ovf_v), 64'(1));
    do_op(0, 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, "no ovf add", ovf_v);
    chk("ovf clear", 64'(ovf_v), 64'(0));
`endif

    // Arbitration from reset with both requesters always valid.
    apply_reset();
    grant_exp[0] = 2'b01; grant_exp[1] = 2'b10; grant_exp[2] = 2'b01; grant_exp[3] = 2'b10;
    drive_req(0, 1'b0, $urandom, $urandom);
    drive_req(1, 1'b1, $urandom, $urandom);
    for (int g = 0; g < 4; g++) begin
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge sys_clk);
        got = (req_ready != '0);
      end
      chk($sformatf("arb grant %0d", g), 64'(req_ready), 64'(grant_exp[g]));
    end
    @(posedge sys_clk); #2;
    req_valid = '0;
    wait_idle("arb");

    // Backpressure with the other requester's rsp_ready high and a competing request.
    @(posedge sys_clk); #2;
    rsp_ready = 2'b10;
    drive_req(0, 1'b0, 32'd100, 32'd23);
    wait_accept(0, "bp op0");
    @(posedge sys_clk); #2;
    req_valid[0] = 1'b0;
    drive_req(1, 1'b1, 32'd4, 32'd9);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge sys_clk);
      got = rsp_valid[0];
    end
    chk("bp rsp arrives", 64'(got), 64'(1));
    snap = rsp_sum;
    chk("bp sum", 64'(snap), 64'(123));
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      chk("bp hold", 64'({rsp_valid, busy, req_ready}), 64'({2'b01, 1'b1, 2'b00}));
      chk("bp sum hold", 64'(rsp_sum), 64'(snap));
    end
    @(posedge sys_clk); #2;
    rsp_ready = '1;
    @(negedge sys_clk);
    chk("bp release cycle", 64'({rsp_valid, req_ready}), 64'({2'b01, 2'b00}));
    @(negedge sys_clk);
    chk("bp next grant", 64'(req_ready), 64'(2'b10));
    @(posedge sys_clk); #2;
    req_valid = '0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge sys_clk);
      got = rsp_valid[1];
    end
    chk("bp op1 result", 64'({got, rsp_cout, rsp_sum}), 64'({1'b1, 1'b1, 32'd5}));
    wait_idle("bp");

    // Randomized traffic; the model process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge sys_clk); #2;
      req_valid = NUM_REQ'($urandom);
      for (int r = 0; r < NUM_REQ; r++)
        if ($urandom_range(0, 2) == 0) begin
          req_operA[r*WIDTH +: WIDTH] = pick_operand();
          req_operB[r*WIDTH +: WIDTH] = pick_operand();
          req_sub[r] = 1'($urandom);
        end
      rsp_ready = ($urandom_range(0, 3) == 0) ? '0 : NUM_REQ'($urandom);
    end
    @(posedge sys_clk); #2;
    req_valid = '0;
    rsp_ready = '1;
    wait_idle("random drain");
    chk("queue drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
